// File: rtl/memory_bidi_responder.sv
// memory_bidi_responder: word-addressed RAM responder with read wait states, ready handshake
// and explicit read-data output enable.
module memory_bidi_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        read_write,
    input  logic [15:0] address,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_oe,
    output logic        ready,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRIVE} state_t;

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] addr_q, rd_idx;
    logic          oor_q, oor, rd_oor, accept;

    assign oor     = 32'(address) >= DEPTH;
    assign accept  = state == S_IDLE && enable;
    assign ready   = state != S_WAIT;
    assign data_oe = state == S_DRIVE;
    // with zero wait states the fetch happens on the accept edge, before the latch is valid
    assign rd_idx  = state == S_IDLE ? address[AW-1:0] : addr_q;
    assign rd_oor  = state == S_IDLE ? oor : oor_q;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_IDLE: if (accept && read_write) begin
                state_n = WAIT_STATES == 0 ? S_DRIVE : S_WAIT;
                cnt_n   = 4'(WAIT_STATES);
            end
            S_WAIT: begin
                state_n = !enable ? S_IDLE : cnt == 4'd1 ? S_DRIVE : S_WAIT;
                cnt_n   = cnt - 4'd1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            data_out <= '0;
            err      <= 1'b0;
            addr_q   <= '0;
            oor_q    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            err   <= accept && oor;
            if (accept && read_write) begin
                addr_q <= address[AW-1:0];
                oor_q  <= oor;
            end
            if (state_n == S_DRIVE)
                data_out <= rd_oor ? 16'h0000 : mem[rd_idx];
        end
    end

    always_ff @(posedge clk)
        if (!reset && accept && !read_write && !oor)
            mem[address[AW-1:0]] <= data_in;
endmodule

// File: tb/tb_memory_bidi_responder.sv
// tb_memory_bidi_responder: three responders (0, 1 and 3 wait states) checked against a
// cycle-count and array reference model, directed cases plus randomized traffic.
module tb_memory_bidi_responder;
    localparam int WSV [3] = '{0, 1, 3};
    localparam int DEPTH = 1024;

    logic        clk = 0;
    logic        reset = 1;
    logic        en [3];
    logic        rw [3];
    logic [15:0] ad [3];
    logic [15:0] di [3];
    logic [15:0] dout [3];
    logic        oe [3];
    logic        rdy [3];
    logic        er [3];

    logic [15:0] mm [3][DEPTH];
    bit          kn [3][DEPTH];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        memory_bidi_responder #(.DEPTH(DEPTH), .WAIT_STATES(WSV[g])) dut (
            .clk(clk), .reset(reset), .enable(en[g]), .read_write(rw[g]),
            .address(ad[g]), .data_in(di[g]), .data_out(dout[g]),
            .data_oe(oe[g]), .ready(rdy[g]), .err(er[g])
        );
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_oor(input logic [15:0] a);
        return 32'(a) >= DEPTH;
    endfunction

    task automatic wr(input int k, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        en[k] = 1; rw[k] = 0; ad[k] = a; di[k] = d;
        check($sformatf("wr_ready%0d", k), 16'(rdy[k]), 16'd1);
        @(posedge clk);
        #1;
        check($sformatf("wr_err%0d", k), 16'(er[k]), 16'(is_oor(a)));
        check($sformatf("wr_ready_after%0d", k), 16'(rdy[k]), 16'd1);
        en[k] = 0;
        if (!is_oor(a)) begin
            mm[k][a[9:0]] = d;
            kn[k][a[9:0]] = 1;
        end
    endtask

    task automatic rd(input int k, input logic [15:0] a);
        int ws = WSV[k];
        @(negedge clk);
        en[k] = 1; rw[k] = 1; ad[k] = a;
        check($sformatf("rd_ready%0d", k), 16'(rdy[k]), 16'd1);
        check($sformatf("rd_oe_idle%0d", k), 16'(oe[k]), 16'd0);
        @(posedge clk);
        #1;
        rw[k] = 1'($urandom);
        ad[k] = 16'($urandom);
        for (int c = 1; c <= ws + 1; c++) begin
            @(negedge clk);
            check($sformatf("rd_oe%0d_c%0d", k, c), 16'(oe[k]), 16'(c == ws + 1));
            check($sformatf("rd_ready%0d_c%0d", k, c), 16'(rdy[k]), 16'(c == ws + 1));
            check($sformatf("rd_err%0d_c%0d", k, c), 16'(er[k]), 16'(c == 1 && is_oor(a)));
            if (c == ws + 1 && (is_oor(a) || kn[k][a[9:0]]))
                check($sformatf("rd_data%0d_%h", k, a), dout[k], is_oor(a) ? 16'h0000 : mm[k][a[9:0]]);
        end
        en[k] = 0;
        @(posedge clk);
    endtask

    task automatic idle(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en[k] = 0;
            check($sformatf("idle_ready%0d", k), 16'(rdy[k]), 16'd1);
            check($sformatf("idle_oe%0d", k), 16'(oe[k]), 16'd0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_ready%0d", tag, k), 16'(rdy[k]), 16'd1);
            check($sformatf("%s_oe%0d", tag, k), 16'(oe[k]), 16'd0);
            check($sformatf("%s_err%0d", tag, k), 16'(er[k]), 16'd0);
            check($sformatf("%s_dout%0d", tag, k), dout[k], 16'h0000);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            en[k] = 0; rw[k] = 0; ad[k] = 0; di[k] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0;
        check_reset_state("reset");

        // basic write then read-back on the one-wait-state responder
        wr(1, 16'h0000, 16'h5A5A);
        wr(1, 16'h0010, 16'hA5A5);
        rd(1, 16'h0000);
        rd(1, 16'h0010);

        // latency on every wait-state setting
        for (int k = 0; k < 3; k++) begin
            wr(k, 16'h0005, 16'h1111 * 16'(k + 1));
            rd(k, 16'h0005);
            rd(k, 16'h0005);
        end

        // abort a three-wait-state read after one wait cycle
        wr(2, 16'h0010, 16'hCAFE);
        @(negedge clk);
        en[2] = 1; rw[2] = 1; ad[2] = 16'h0010;
        @(posedge clk);
        @(negedge clk);
        check("abort_wait_ready", 16'(rdy[2]), 16'd0);
        en[2] = 0;
        idle(2, 5);
        wr(2, 16'h0010, 16'h1234);
        rd(2, 16'h0010);

        // out-of-range write and read
        wr(1, 16'h03FF, 16'h7E57);
        wr(1, 16'hFFFF, 16'hDEAD);
        rd(1, 16'h03FF);
        rd(1, 16'h0400);
        rd(0, 16'h0400);

        // reset during WAIT
        @(negedge clk);
        en[2] = 1; rw[2] = 1; ad[2] = 16'h0010;
        @(posedge clk);
        @(negedge clk);
        reset = 1; en[2] = 0;
        @(negedge clk);
        reset = 0;
        check_reset_state("rst_wait");
        // reset during DRIVE
        @(negedge clk);
        en[1] = 1; rw[1] = 1; ad[1] = 16'h0000;
        @(posedge clk);
        repeat (2) @(negedge clk);
        check("rst_drive_oe", 16'(oe[1]), 16'd1);
        reset = 1; en[1] = 0;
        @(negedge clk);
        reset = 0;
        check_reset_state("rst_drive");
        rd(1, 16'h0000);
        rd(2, 16'h0010);

        // write immediately followed by read of the same word
        wr(1, 16'h0020, 16'hBEEF);
        rd(1, 16'h0020);
        wr(0, 16'h0020, 16'hBEEF);
        rd(0, 16'h0020);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            int k = int'($urandom_range(0, 2));
            int sel = int'($urandom_range(0, 9));
            logic [15:0] a = sel == 0 ? 16'($urandom) : sel == 1 ? 16'($urandom_range(1020, 1030))
                                                               : 16'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 0) wr(k, a, 16'($urandom));
            else rd(k, a);
            if ($urandom_range(0, 3) == 0) idle(k, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
